vid_timing_gen: RTL and testbench
=================================

VID_TIMING_GEN -- requirements
Module: vid_timing_gen

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low.
REQ-002 Parameter CW, default 12: width of hcount/vcount; H and V totals SHALL fit in CW bits.
REQ-003 Parameters H_ACTIVE, H_FP, H_SYNC, H_BP SHALL default to 1280, 110, 40, 220; HT = their sum = 1650.
REQ-004 Parameters V_ACTIVE, V_FP, V_SYNC, V_BP SHALL default to 720, 5, 5, 20; VT = their sum = 750.
REQ-005 Parameter START_DELAY, default 33000: cycles from accepted frame_start to first active pixel; DW, default 16: delay counter width.
REQ-006 Parameters HS_POL and VS_POL, default 0: sync assert level is 1 when 0, and 0 when 1 (output = raw XOR POL).
REQ-007 Parameter OUT_LAT, default 2, range 1..4: register stages on hsync/vsync/de/hblnk/vblnk.
REQ-008 Port tmds_clk, input, 1: pixel clock.
REQ-009 Port sys_rst_n, input, 1: synchronous active-low reset.
REQ-010 Port frame_start, input, 1: single-cycle pulse marking arrival of a new frame's data.
REQ-011 Ports hcount and vcount, output, CW each: current pixel and line counters.
REQ-012 Ports hsync and vsync, output, 1 each: polarity-adjusted sync signals.
REQ-013 Ports de, hblnk and vblnk, output, 1 each: data enable and blanking flags.
REQ-014 Port frame_done, output, 1: one-cycle pulse at the last pixel of a frame.
REQ-015 Port busy, output, 1: high in ARM or RUN.

Function
REQ-016 The FSM SHALL have states IDLE, ARM and RUN.
REQ-017 IDLE -> ARM on frame_start; ARM SHALL clear the delay counter to 0.
REQ-018 ARM SHALL increment the delay counter each cycle and go to RUN the cycle after the count equals START_DELAY-1.
REQ-019 RUN SHALL enter with hcount=0 and vcount=0.
REQ-020 In RUN, hcount SHALL wrap from HT-1 to 0, and vcount SHALL increment on each wrap.
REQ-021 At hcount=HT-1 and vcount=VT-1, frame_done SHALL pulse and the FSM SHALL leave RUN; counters then hold 0.
REQ-022 A frame_start in RUN SHALL set a pending flag; at frame end with pending set, the FSM SHALL go to ARM (pending cleared), otherwise to IDLE.
REQ-023 A frame_start at the frame-end cycle SHALL count as pending.
REQ-024 A frame_start in ARM SHALL be ignored; the delay SHALL not restart.
REQ-025 The raw signals SHALL be defined as follows:
- de = RUN && hcount<H_ACTIVE && vcount<V_ACTIVE.
- hblnk = hcount>=H_ACTIVE.
- vblnk = vcount>=V_ACTIVE, or not in RUN.
- hsync raw = RUN && H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
- vsync raw = not RUN, or (V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC).
REQ-026 Vsync SHALL be held asserted while IDLE/ARM, so that the sink sees blanking while the block waits for data.
REQ-027 hsync, vsync, de, hblnk and vblnk SHALL appear exactly OUT_LAT cycles after the hcount/vcount value they describe.
REQ-028 hcount, vcount, frame_done and busy SHALL be registered with zero added latency.

Reset
REQ-029 While sys_rst_n=0 at a tmds_clk edge, the block SHALL set:
- state=IDLE;
- counters, delay counter and pending = 0;
- frame_done=0, busy=0;
- de=0, hblnk=0, vblnk=1;
- hsync deasserted, vsync asserted (polarity applied), including all OUT_LAT pipeline stages.
REQ-030 Reset asserted mid-frame SHALL abort RUN/ARM on that edge with no frame_done pulse.

Configuration
REQ-031 With macro VTG_FREERUN_EN defined, the parameter FREERUN_TIMEOUT (default 49500) SHALL be active.
REQ-032 With VTG_FREERUN_EN defined, if IDLE persists FREERUN_TIMEOUT cycles without frame_start, the FSM SHALL go directly to RUN (no ARM) and raise output freerun for that frame.
REQ-033 With VTG_FREERUN_EN defined, freerun SHALL clear when a frame is entered through ARM.
REQ-034 Without VTG_FREERUN_EN, IDLE SHALL wait indefinitely, the freerun port and parameter SHALL not exist, and no timeout logic SHALL be synthesised.

Verification
REQ-035 The bench SHALL use H=8/2/2/4 (HT=16), V=4/1/1/2 (VT=8), START_DELAY=5 and OUT_LAT=2 unless a scenario states otherwise.
REQ-036 Reset then frame_start at cycle 0 -> busy rises, first de=1 at cycle 7, frame_done at cycle 5+127=132, then IDLE with vsync asserted.
REQ-037 Second frame_start in RUN at vcount=3 -> at frame_done the FSM goes to ARM, and the next RUN starts 5 cycles later with no IDLE cycle.
REQ-038 frame_start pulses during ARM -> RUN entry cycle unchanged (5 cycles after the first pulse).
REQ-039 HS_POL=1, VS_POL=1 -> hsync low exactly when hcount=10..11 (delayed 2 cycles); vsync low in IDLE.
REQ-040 sys_rst_n low at hcount=5, vcount=2 -> next cycle all outputs at reset values and no frame_done; OUT_LAT=4 run -> sync/de offset 4 cycles.
REQ-041 With VTG_FREERUN_EN and FREERUN_TIMEOUT=20, no frame_start -> RUN entered at cycle 20 with freerun=1; a later frame_start-driven frame -> freerun=0.

Source files
------------

// File: rtl/vid_timing_gen_if.sv
// Video timing bundle between the timing generator (master) and its sink
// (slave). The sink raises frame_start when a new frame's data is available
// and receives counters, sync/blanking flags and status.
// Optional feature macro: VTG_FREERUN_EN adds the freerun status signal.
interface vid_timing_gen_if #(
    parameter int CW = 12
);
    logic          frame_start;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          hblnk;
    logic          vblnk;
    logic          frame_done;
    logic          busy;
`ifdef VTG_FREERUN_EN
    logic          freerun;
`endif

    modport master (
`ifdef VTG_FREERUN_EN
        output freerun,
`endif
        input  frame_start,
        output hcount, vcount, hsync, vsync, de, hblnk, vblnk, frame_done, busy
    );

    modport slave (
`ifdef VTG_FREERUN_EN
        input  freerun,
`endif
        output frame_start,
        input  hcount, vcount, hsync, vsync, de, hblnk, vblnk, frame_done, busy
    );
endinterface

// File: rtl/vid_timing_gen.sv
// Video timing generator. A frame_start pulse arms a start delay, after which
// one full frame of hcount/vcount is produced together with sync, data-enable
// and blanking flags delayed by OUT_LAT register stages. A frame_start seen
// while a frame runs is remembered and chains the next frame through ARM.
// Optional feature macro: VTG_FREERUN_EN -- when defined, an IDLE period of
// FREERUN_TIMEOUT cycles without frame_start starts a frame on its own and
// raises freerun for it.
module vid_timing_gen #(
    parameter int CW          = 12,
    parameter int H_ACTIVE    = 1280,
    parameter int H_FP        = 110,
    parameter int H_SYNC      = 40,
    parameter int H_BP        = 220,
    parameter int V_ACTIVE    = 720,
    parameter int V_FP        = 5,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 20,
    parameter int START_DELAY = 33000,
    parameter int DW          = 16,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int OUT_LAT     = 2
`ifdef VTG_FREERUN_EN
    ,
    parameter int FREERUN_TIMEOUT = 49500
`endif
) (
    input logic              tmds_clk,
    input logic              sys_rst_n,
    vid_timing_gen_if.master vif
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic hblnk;
        logic vblnk;
    } vid_flags_t;

    // Idle/reset flag levels with polarity applied: sink sees blanking.
    localparam vid_flags_t FLAGS_RST = '{
        hsync: HS_POL, vsync: ~VS_POL, de: 1'b0, hblnk: 1'b0, vblnk: 1'b1
    };

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          pending_q, pending_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;
    vid_flags_t    raw_flags;
    vid_flags_t    pipe_q [OUT_LAT];
    vid_flags_t    pipe_d [OUT_LAT];
    logic          run;

`ifdef VTG_FREERUN_EN
    localparam int TW = (FREERUN_TIMEOUT > 1) ? $clog2(FREERUN_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(FREERUN_TIMEOUT - 1);

    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          freerun_q, freerun_d;
`endif

    // Next-state logic: FSM, start delay, pixel/line counters and frame chaining.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        dly_d     = dly_q;
        hcount_d  = '0;
        vcount_d  = '0;
        pending_d = pending_q;
`ifdef VTG_FREERUN_EN
        freerun_d  = freerun_q;
        idle_cnt_d = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (vif.frame_start) begin
                    state_d = ST_ARM;
                    dly_d   = '0;
`ifdef VTG_FREERUN_EN
                    freerun_d = 1'b0;
                end else if (idle_cnt_q == TO_LAST) begin
                    state_d   = ST_RUN;
                    freerun_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
`endif
                end
            end
            ST_ARM: begin
                // frame_start is deliberately not looked at: the delay never restarts.
                dly_d = dly_q + DW'(1);
                if (dly_q == DLY_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pending_d = pending_q | vif.frame_start;
                hcount_d  = hcount_q + CW'(1);
                vcount_d  = vcount_q;
                if (hcount_q == H_LAST) begin
                    hcount_d = '0;
                    if (vcount_q == V_LAST) begin
                        vcount_d  = '0;
                        pending_d = 1'b0;
                        // A frame_start on the frame-end cycle itself also chains.
                        if (pending_q || vif.frame_start) begin
                            state_d = ST_ARM;
                            dly_d   = '0;
`ifdef VTG_FREERUN_EN
                            freerun_d = 1'b0;
`endif
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        vcount_d = vcount_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Status is derived from next values so it lines up with the counters.
        frame_done_d = (state_d == ST_RUN) && (hcount_d == H_LAST) && (vcount_d == V_LAST);
        busy_d       = (state_d != ST_IDLE);
    end

    // Raw timing flags for the current counter values, polarity applied.
    always_comb begin
        run             = (state_q == ST_RUN);
        raw_flags.de    = run && (hcount_q < H_ACT) && (vcount_q < V_ACT);
        raw_flags.hblnk = (hcount_q >= H_ACT);
        raw_flags.vblnk = (vcount_q >= V_ACT) || !run;
        raw_flags.hsync = (run && (hcount_q >= HS_BEG) && (hcount_q < HS_END)) ^ HS_POL;
        raw_flags.vsync = (!run || ((vcount_q >= VS_BEG) && (vcount_q < VS_END))) ^ VS_POL;
    end

    // Output delay line: stage 0 takes the raw flags, later stages shift.
    always_comb begin
        pipe_d[0] = raw_flags;
        for (int i = 1; i < OUT_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge tmds_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            dly_q        <= '0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            // NOTE: the delay-line stages are reset too, otherwise stale
            // sync/enable levels would leak out for OUT_LAT cycles after reset.
            for (int i = 0; i < OUT_LAT; i++) begin
                pipe_q[i] <= FLAGS_RST;
            end
`ifdef VTG_FREERUN_EN
            idle_cnt_q <= '0;
            freerun_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            pipe_q       <= pipe_d;
`ifdef VTG_FREERUN_EN
            idle_cnt_q <= idle_cnt_d;
            freerun_q  <= freerun_d;
`endif
        end
    end

    assign vif.hcount     = hcount_q;
    assign vif.vcount     = vcount_q;
    assign vif.frame_done = frame_done_q;
    assign vif.busy       = busy_q;
    assign vif.hsync      = pipe_q[OUT_LAT-1].hsync;
    assign vif.vsync      = pipe_q[OUT_LAT-1].vsync;
    assign vif.de         = pipe_q[OUT_LAT-1].de;
    assign vif.hblnk      = pipe_q[OUT_LAT-1].hblnk;
    assign vif.vblnk      = pipe_q[OUT_LAT-1].vblnk;
`ifdef VTG_FREERUN_EN
    assign vif.freerun    = freerun_q;
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: three instances share stimulus
// (g=0 default polarity OUT_LAT=2, g=1 inverted polarity, g=2 OUT_LAT=4).
// Stimulus pushes expected output edges (cycle, level) into per-signal queues;
// a negedge monitor pops and compares whenever an output pin changes.
// With VTG_FREERUN_EN defined, instances get FREERUN_TIMEOUT=20 and a
// free-run scenario is added.
module tb_vid_timing_gen;
    localparam int CW = 12;
    localparam int NI = 3;
    localparam int NK = 7;
    localparam int NQ = NI * NK;

    typedef struct packed {
        int   cyc;
        logic lvl;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_start;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;

    ev_t           exp_q [NQ][$];
    logic [NK-1:0] pins [NI];
    logic [NK-1:0] prev [NI];
    logic [CW-1:0] hcnt [NI];
    logic [CW-1:0] vcnt [NI];
`ifdef VTG_FREERUN_EN
    logic          fr [NI];
`endif
    string kname [NK] = '{"frame_done", "busy", "hsync", "vsync", "de", "hblnk", "vblnk"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vid_timing_gen_if #(.CW(CW)) vif ();
        assign vif.frame_start = frame_start;
        assign pins[g] = {vif.vblnk, vif.hblnk, vif.de, vif.vsync, vif.hsync, vif.busy, vif.frame_done};
        assign hcnt[g] = vif.hcount;
        assign vcnt[g] = vif.vcount;
`ifdef VTG_FREERUN_EN
        assign fr[g] = vif.freerun;
`endif
        vid_timing_gen #(
            .CW(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
            .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
            .START_DELAY(5), .DW(16),
            .HS_POL(g == 1), .VS_POL(g == 1), .OUT_LAT((g == 2) ? 4 : 2)
`ifdef VTG_FREERUN_EN
            , .FREERUN_TIMEOUT(20)
`endif
        ) u_dut (
            .tmds_clk (clk),
            .sys_rst_n(rst_n),
            .vif      (vif)
        );
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input int g, input int k, input int c, input logic l);
        ev_t e;
        e.cyc = c;
        e.lvl = l;
        exp_q[g*NK + k].push_back(e);
    endtask

    task automatic push_busy(input int c, input logic l);
        for (int g = 0; g < NI; g++) push_ev(g, 1, c, l);
    endtask

    // Hand-derived edges of one 16x8 frame whose first pixel shows at cycle rs.
    task automatic push_frame(input int rs, input bit to_idle);
        for (int g = 0; g < NI; g++) begin
            int   lat;
            logic hp;
            logic vp;
            lat = (g == 2) ? 4 : 2;
            hp  = (g == 1);
            vp  = (g == 1);
            push_ev(g, 0, rs + 127, 1'b1);
            push_ev(g, 0, rs + 128, 1'b0);
            if (to_idle) push_ev(g, 1, rs + 128, 1'b0);
            for (int l = 0; l < 8; l++) begin
                push_ev(g, 2, rs + 16*l + 10 + lat, 1'b1 ^ hp);
                push_ev(g, 2, rs + 16*l + 12 + lat, 1'b0 ^ hp);
                push_ev(g, 5, rs + 16*l + 8 + lat, 1'b1);
                push_ev(g, 5, rs + 16*l + 16 + lat, 1'b0);
            end
            push_ev(g, 3, rs + lat, 1'b0 ^ vp);
            push_ev(g, 3, rs + 80 + lat, 1'b1 ^ vp);
            push_ev(g, 3, rs + 96 + lat, 1'b0 ^ vp);
            push_ev(g, 3, rs + 128 + lat, 1'b1 ^ vp);
            for (int l = 0; l < 4; l++) begin
                push_ev(g, 4, rs + 16*l + lat, 1'b1);
                push_ev(g, 4, rs + 16*l + 8 + lat, 1'b0);
            end
            push_ev(g, 6, rs + lat, 1'b0);
            push_ev(g, 6, rs + 64 + lat, 1'b1);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drive frame_start so that the rising edge numbered c samples it.
    task automatic fs_at(input int c);
        if (cyc > c - 1) begin
            n_checks++;
            n_errors++;
            $display("FAIL fs_schedule: at cycle %0d, needed to drive by %0d", cyc, c - 1);
        end
        wait_until(c - 1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("%s_hcount_g%0d", tag, g), int'(hcnt[g]), 0);
            check($sformatf("%s_vcount_g%0d", tag, g), int'(vcnt[g]), 0);
            check($sformatf("%s_frame_done_g%0d", tag, g), int'(pins[g][0]), 0);
            check($sformatf("%s_busy_g%0d", tag, g), int'(pins[g][1]), 0);
            check($sformatf("%s_hsync_g%0d", tag, g), int'(pins[g][2]), (g == 1) ? 1 : 0);
            check($sformatf("%s_vsync_g%0d", tag, g), int'(pins[g][3]), (g == 1) ? 0 : 1);
            check($sformatf("%s_de_g%0d", tag, g), int'(pins[g][4]), 0);
            check($sformatf("%s_hblnk_g%0d", tag, g), int'(pins[g][5]), 0);
            check($sformatf("%s_vblnk_g%0d", tag, g), int'(pins[g][6]), 1);
`ifdef VTG_FREERUN_EN
            check($sformatf("%s_freerun_g%0d", tag, g), int'(fr[g]), 0);
`endif
        end
    endtask

    task automatic check_pos(input string tag, input int h, input int v);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("%s_hcount_g%0d", tag, g), int'(hcnt[g]), h);
            check($sformatf("%s_vcount_g%0d", tag, g), int'(vcnt[g]), v);
        end
    endtask

    // Monitor: every pin change must match the next queued expectation.
    always @(negedge clk) begin
        ev_t e;
        int  idx;
        for (int g = 0; g < NI; g++) begin
            for (int k = 0; k < NK; k++) begin
                if (mon_en && (pins[g][k] !== prev[g][k])) begin
                    idx = g*NK + k;
                    if (exp_q[idx].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_%s_g%0d: changed to %b at cycle %0d, no change expected",
                                 kname[k], g, pins[g][k], cyc);
                    end else begin
                        e = exp_q[idx].pop_front();
                        check($sformatf("%s_g%0d_cycle", kname[k], g), cyc, e.cyc);
                        check($sformatf("%s_g%0d_level", kname[k], g), int'(pins[g][k]), int'(e.lvl));
                    end
                end
            end
            prev[g] = pins[g];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int rs;
        int rs2;
        int rs3;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single frame from IDLE, back to IDLE with vsync asserted.
        c = cyc + 3;
        push_busy(c, 1'b1);
        push_frame(c + 5, 1'b1);
        fs_at(c);
        wait_until(c + 5 + 37);
        check_pos("single", 5, 2);
        wait_until(c + 5 + 130);

        // Chained frames: pending from vcount=3, then frame_start on the frame-end cycle.
        c  = cyc + 2;
        rs = c + 5;
        push_busy(c, 1'b1);
        push_frame(rs, 1'b0);
        fs_at(c);
        rs2 = rs + 133;
        push_frame(rs2, 1'b0);
        fs_at(rs + 49);
        rs3 = rs2 + 133;
        push_frame(rs3, 1'b1);
        fs_at(rs2 + 128);
        wait_until(rs3 + 130);

        // frame_start pulses during ARM must not move the RUN entry.
        c = cyc + 2;
        push_busy(c, 1'b1);
        push_frame(c + 5, 1'b1);
        fs_at(c);
        fs_at(c + 2);
        fs_at(c + 4);
        wait_until(c + 5 + 130);

        // Reset in the middle of a frame at hcount=5, vcount=2.
        c  = cyc + 2;
        rs = c + 5;
        push_busy(c, 1'b1);
        push_frame(rs, 1'b1);
        fs_at(c);
        wait_until(rs + 37);
        check_pos("pre_abort", 5, 2);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        check_reset_vals("abort");
        rst_n = 1'b1;
        for (int i = 0; i < NQ; i++) exp_q[i].delete();
        @(negedge clk);
        mon_en = 1'b1;

`ifdef VTG_FREERUN_EN
        // Free-run: no frame_start for 20 cycles after the last reset edge.
        rst_n = 1'b0;
        @(negedge clk);
        c     = cyc;
        rst_n = 1'b1;
        rs    = c + 20;
        push_busy(rs, 1'b1);
        push_frame(rs, 1'b1);
        wait_until(rs + 10);
        for (int g = 0; g < NI; g++) check($sformatf("freerun_on_g%0d", g), int'(fr[g]), 1);
        wait_until(rs + 129);
        c = cyc + 2;
        push_busy(c, 1'b1);
        push_frame(c + 5, 1'b1);
        fs_at(c);
        wait_until(c + 5 + 10);
        for (int g = 0; g < NI; g++) check($sformatf("freerun_off_g%0d", g), int'(fr[g]), 0);
        wait_until(c + 5 + 134);
`endif

        repeat (2) @(negedge clk);
        for (int i = 0; i < NQ; i++) begin
            check($sformatf("leftover_%s_g%0d", kname[i % NK], i / NK), exp_q[i].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
